inv_shift_rows_buf: RTL

INV_SHIFT_ROWS_BUF -- requirements
Module: inv_shift_rows_buf

---
 rtl/inv_shift_rows_buf.sv | 95 +++++++++
 1 files changed

// File: rtl/inv_shift_rows_buf.sv
`default_nettype none
// ============================================================================
// Module      : inv_shift_rows_buf
// Description : Two-entry in-order FIFO for AES states. InvShiftRows is
//               applied as a state is written, so the stored entries are
//               already transformed. A sideband tag is carried unmodified
//               alongside each state.
//
// Ports       : clk      - clock, all state updates on the rising edge
//               rst      - synchronous active-high reset
//               i_valid  - upstream state valid
//               o_ready  - block can accept a state this cycle
//               i_data   - AES state, row-major, row r = [127-32r -: 32]
//               i_tag    - sideband tag stored with the state
//               o_valid  - head entry valid
//               i_ready  - downstream accepts the head entry
//               o_data   - transformed head state (zero when empty)
//               o_tag    - tag of the head entry (zero when empty)
//               o_count  - occupancy, 0..2
//
// Revision    : 1.0 - initial release
// ============================================================================
module inv_shift_rows_buf #(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [127:0]       i_data,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [127:0]       o_data,
    output logic [TAG_W-1:0]   o_tag,
    output logic [1:0]         o_count
);

    localparam logic [1:0] c_full = 2'd2;

    logic [127:0]     r_data [0:1];
    logic [TAG_W-1:0] r_tag  [0:1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic [127:0]     w_shifted;
    logic             w_push;
    logic             w_pop;

    // Row r rotates right by r bytes; byte 0 of each row sits in its MSB.
    assign w_shifted = {i_data[127:96],
                        i_data[71:64],  i_data[95:72],
                        i_data[47:32],  i_data[63:48],
                        i_data[23:0],   i_data[31:24]};

    // o_ready depends only on registered occupancy and rst, never on i_ready,
    // so a pop in the same cycle does not open a slot for a push when full.
    assign o_ready = !rst && (r_count != c_full);
    assign o_valid = (r_count != 2'd0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    assign o_data  = o_valid ? r_data[r_rptr] : 128'd0;
    assign o_tag   = o_valid ? r_tag[r_rptr]  : {TAG_W{1'b0}};
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= 128'd0;
                r_tag[i]  <= {TAG_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_shifted;
                r_tag[r_wptr]  <= i_tag;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
